multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RV32I-subset datapath: PC, instruction register, register file, ALU, sign extender, register write-back mux and data memory.
- Replaces the single-cycle combinational decoder. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives all datapath strobes and selects.
- Handles variable-latency instruction and data memories with a req/ready handshake.
- Traps permanently on an illegal instruction or a memory timeout.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/instr_decoder.sv | 85 ++++++++
 rtl/multicycle_control_fsm.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I-subset multi-cycle controller:
// ALU/immediate/write-back encodings, opcodes, funct fields and FSM states.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_BPASS = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        SEXT_ADDI = 3'd0,
        SEXT_SLLI = 3'd1,
        SEXT_SW   = 3'd2,
        SEXT_LUI  = 3'd3
    } sign_extend_t;

    typedef enum logic [1:0] {
        MUX_ALU       = 2'd0,
        MUX_MEM       = 2'd1,
        MUX_PC_PLUS_4 = 2'd2
    } REGISTER_DATA_IN_MUX_SEL;

    typedef enum logic [6:0] {
        OP_R_TYPE = 7'b0110011,
        OP_I_TYPE = 7'b0010011,
        OP_LUI    = 7'b0110111,
        OP_LW     = 7'b0000011,
        OP_SW     = 7'b0100011
    } OPCODE_TYPE;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } ctrl_state_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier: opcode/funct3/funct7 to legality,
// memory-access kind and the ALU/immediate selects used in EXECUTE and MEM.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output logic         illegal,
    output logic         is_load,
    output logic         is_store,
    output alu_op_t      alu_op,
    output logic         use_imm,
    output sign_extend_t sign_extend_type
);

    always_comb begin
        illegal          = 1'b0;
        is_load          = 1'b0;
        is_store         = 1'b0;
        alu_op           = ALU_ADD;
        use_imm          = 1'b0;
        sign_extend_type = SEXT_ADDI;

        case (opcode)
            OP_R_TYPE: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_ADD;
                        else if (funct7 == F7_ALT) alu_op = ALU_SUB;
                        else                       illegal = 1'b1;
                    end
                    F3_SLL:     alu_op = ALU_SLL;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_SRL_SRA: alu_op = ALU_SRL;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    default:    illegal = 1'b1;
                endcase
                // only ADD/SUB accept a non-zero funct7
                if (funct3 != F3_ADD_SUB && funct7 != F7_BASE)
                    illegal = 1'b1;
            end
            OP_I_TYPE: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD_SUB: alu_op = ALU_ADD;
                    F3_SLL: begin
                        alu_op           = ALU_SLL;
                        sign_extend_type = SEXT_SLLI;
                    end
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_SRL_SRA: begin
                        sign_extend_type = SEXT_SLLI;
                        if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    default:    illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                alu_op           = ALU_BPASS;
                use_imm          = 1'b1;
                sign_extend_type = SEXT_LUI;
            end
            OP_LW: begin
                is_load = 1'b1;
                use_imm = 1'b1;
                illegal = (funct3 != F3_WORD);
            end
            OP_SW: begin
                is_store         = 1'b1;
                use_imm          = 1'b1;
                sign_extend_type = SEXT_SW;
                illegal          = (funct3 != F3_WORD);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV32I-subset datapath with req/ready memory
// handshakes, sticky trap and wait timeout. Optional macro: PERF_COUNTERS_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | instr_req until instr_ready; then load IR and bump PC
// DECODE    | one idle cycle while the opcode is classified
// EXECUTE   | ALU/LUI write back, or address calculation for LW/SW
// MEM       | data_req (+data_we for SW) until data_ready
// WRITEBACK | load data written to the register file
// TRAP      | illegal instruction or timeout; left only by reset
module multicycle_control_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_W   = 5    // MEM_TIMEOUT must be < 2**TIMEOUT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       instr_req,
    input  logic       instr_ready,
    output logic       data_req,
    output logic       data_we,
    input  logic       data_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [3:0] alu_op,
    output logic       use_imm,
    output logic [2:0] sign_extend_type,
    output logic [1:0] register_data_in_mux_sel,
    output logic       trap,
    output logic [2:0] state_check
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic                 w_timeout;
    logic                 w_waiting;

    logic                 w_illegal;
    logic                 w_is_load;
    logic                 w_is_store;
    alu_op_t              w_dec_alu_op;
    logic                 w_dec_use_imm;
    sign_extend_t         w_dec_sext;

    instr_decoder u_decoder (
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7           (funct7),
        .illegal          (w_illegal),
        .is_load          (w_is_load),
        .is_store         (w_is_store),
        .alu_op           (w_dec_alu_op),
        .use_imm          (w_dec_use_imm),
        .sign_extend_type (w_dec_sext)
    );

    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));
    assign w_waiting = (r_state == ST_FETCH && !instr_ready) ||
                       (r_state == ST_MEM && !data_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clearing on every state change covers entry into both FETCH and MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next             = r_state;
        instr_req                = 1'b0;
        data_req                 = 1'b0;
        data_we                  = 1'b0;
        pc_write                 = 1'b0;
        ir_write                 = 1'b0;
        reg_write                = 1'b0;
        alu_op                   = ALU_ADD;
        use_imm                  = 1'b0;
        sign_extend_type         = SEXT_ADDI;
        register_data_in_mux_sel = MUX_ALU;
        trap                     = 1'b0;

        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    instr_req = 1'b1;
                    if (instr_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_state_next = ST_DECODE;
                    end else if (w_timeout) begin
                        w_state_next = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    w_state_next = w_illegal ? ST_TRAP : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    alu_op           = w_dec_alu_op;
                    use_imm          = w_dec_use_imm;
                    sign_extend_type = w_dec_sext;
                    if (w_is_load || w_is_store) begin
                        w_state_next = ST_MEM;
                    end else begin
                        reg_write    = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
                ST_MEM: begin
                    // selects held from the decoder so the address stays stable
                    alu_op           = w_dec_alu_op;
                    use_imm          = w_dec_use_imm;
                    sign_extend_type = w_dec_sext;
                    data_req         = 1'b1;
                    data_we          = w_is_store;
                    if (data_ready) begin
                        w_state_next = w_is_store ? ST_FETCH : ST_WRITEBACK;
                    end else if (w_timeout) begin
                        w_state_next = ST_TRAP;
                    end
                end
                ST_WRITEBACK: begin
                    reg_write                = 1'b1;
                    register_data_in_mux_sel = MUX_MEM;
                    use_imm                  = 1'b1;
                    alu_op                   = ALU_ADD;
                    sign_extend_type         = w_dec_sext;
                    w_state_next             = ST_FETCH;
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    w_state_next = ST_FETCH;
                end
            endcase
        end
    end

    assign state_check = r_state;

`ifdef PERF_COUNTERS_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret_count;
    logic        w_retire;

    assign w_retire = (r_state == ST_EXECUTE && !(w_is_load || w_is_store)) ||
                      (r_state == ST_MEM && data_ready && w_is_store) ||
                      (r_state == ST_WRITEBACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count   <= '0;
            r_instret_count <= '0;
        end else begin
            if (r_state != ST_TRAP) r_cycle_count <= r_cycle_count + 32'd1;
            if (w_retire)           r_instret_count <= r_instret_count + 32'd1;
        end
    end

    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected control
// vectors go through a scoreboard queue and are checked at the falling edge.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        instr_req;
    logic        instr_ready;
    logic        data_req;
    logic        data_we;
    logic        data_ready;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [2:0]  sign_extend_type;
    logic [1:0]  register_data_in_mux_sel;
    logic        trap;
    logic [2:0]  state_check;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] q_exp[$];
    string       q_tag[$];

    // strobe order: instr_req, data_req, data_we, pc_write, ir_write, reg_write
    localparam logic [5:0] SB_NONE  = 6'b000000;
    localparam logic [5:0] SB_FETCH = 6'b100000;
    localparam logic [5:0] SB_FDONE = 6'b100110;
    localparam logic [5:0] SB_LOAD  = 6'b010000;
    localparam logic [5:0] SB_STORE = 6'b011000;
    localparam logic [5:0] SB_WR    = 6'b000001;

    multicycle_control_fsm dut (
        .clk                      (clk),
        .reset                    (reset),
        .opcode                   (opcode),
        .funct3                   (funct3),
        .funct7                   (funct7),
        .instr_req                (instr_req),
        .instr_ready              (instr_ready),
        .data_req                 (data_req),
        .data_we                  (data_we),
        .data_ready               (data_ready),
        .pc_write                 (pc_write),
        .ir_write                 (ir_write),
        .reg_write                (reg_write),
        .alu_op                   (alu_op),
        .use_imm                  (use_imm),
        .sign_extend_type         (sign_extend_type),
        .register_data_in_mux_sel (register_data_in_mux_sel),
        .trap                     (trap),
        .state_check              (state_check)
`ifdef PERF_COUNTERS_EN
        ,
        .cycle_count              (cycle_count),
        .instret_count            (instret_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] ev(input logic [2:0] st, input logic [5:0] sb,
                                       input logic [3:0] alu, input logic imm,
                                       input logic [2:0] sx, input logic [1:0] mx,
                                       input logic tr);
        return {sb, alu, imm, sx, mx, tr, st};
    endfunction

    task automatic set_instr(input logic [31:0] w);
        opcode = w[6:0];
        funct3 = w[14:12];
        funct7 = w[31:25];
    endtask

    task automatic check_head();
        logic [19:0] exp;
        logic [19:0] obs;
        string       tag;
        exp = q_exp.pop_front();
        tag = q_tag.pop_front();
        obs = {instr_req, data_req, data_we, pc_write, ir_write, reg_write,
               alu_op, use_imm, sign_extend_type, register_data_in_mux_sel,
               trap, state_check};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; drives inputs for this cycle, checks at the falling edge.
    task automatic step(input string tag, input logic ir_rdy, input logic dr_rdy,
                        input logic rst, input logic [19:0] exp);
        instr_ready = ir_rdy;
        data_ready  = dr_rdy;
        reset       = rst;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        @(negedge clk);
        check_head();
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [31:0] w, input logic [3:0] alu,
                           input logic imm, input logic [2:0] sx);
        set_instr(w);
        step({tag, "_fetch"},  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step({tag, "_decode"}, 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step({tag, "_exec"},   1'b0, 1'b0, 1'b0, ev(3'd2, SB_WR, alu, imm, sx, 2'd0, 1'b0));
    endtask

    task automatic run_lw(input string tag, input int waits);
        set_instr(32'h00402103);
        step({tag, "_fetch"},  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step({tag, "_decode"}, 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step({tag, "_exec"},   1'b0, 1'b0, 1'b0, ev(3'd2, SB_NONE, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        for (int i = 0; i < waits; i++)
            step({tag, "_memwait"}, 1'b1, 1'b0, 1'b0, ev(3'd3, SB_LOAD, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        step({tag, "_memdone"}, 1'b0, 1'b1, 1'b0, ev(3'd3, SB_LOAD, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        step({tag, "_wb"},      1'b0, 1'b1, 1'b0, ev(3'd4, SB_WR, 4'd0, 1'b1, 3'd0, 2'd1, 1'b0));
    endtask

    task automatic run_sw(input string tag);
        set_instr(32'h00202423);
        step({tag, "_fetch"},  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step({tag, "_decode"}, 1'b0, 1'b1, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step({tag, "_exec"},   1'b0, 1'b0, 1'b0, ev(3'd2, SB_NONE, 4'd0, 1'b1, 3'd2, 2'd0, 1'b0));
        step({tag, "_mem"},    1'b0, 1'b1, 1'b0, ev(3'd3, SB_STORE, 4'd0, 1'b1, 3'd2, 2'd0, 1'b0));
    endtask

    localparam logic [19:0] EXP_TRAP = {SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd5};
    localparam logic [19:0] EXP_IDLE_FETCH = {SB_FETCH, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0};

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b0;
        data_ready  = 1'b0;
        set_instr(32'h00000013);
        @(posedge clk);
        #1;
        step("reset_state", 1'b1, 1'b1, 1'b1, ev(3'd0, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));

        // ADDI, LW (no wait), SW back to back: 3 + 5 + 4 cycles
        run_alu("addi", 32'h00500093, 4'd0, 1'b1, 3'd0);
        run_lw("lw0", 0);
        run_sw("sw");
`ifdef PERF_COUNTERS_EN
        n_tests++;
        assert (cycle_count === 32'd12) else begin
            n_fail++;
            $error("FAIL cycle_count: observed %0d expected 12", cycle_count);
        end
        n_tests++;
        assert (instret_count === 32'd3) else begin
            n_fail++;
            $error("FAIL instret_count: observed %0d expected 3", instret_count);
        end
`endif

        run_lw("lw3", 3);
        run_alu("sub",  32'h403100B3, 4'd1, 1'b0, 3'd0);
        run_alu("or",   32'h0020E0B3, 4'd3, 1'b0, 3'd0);
        run_alu("srai", 32'h40315093, 4'd7, 1'b1, 3'd1);
        run_alu("lui",  32'h123450B7, 4'd9, 1'b1, 3'd3);

        // illegal opcode, trap ignores ready inputs
        set_instr(32'h0000007F);
        step("ill_fetch",  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("ill_decode", 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        for (int i = 0; i < 20; i++)
            step("ill_trap", logic'(i[0]), logic'(i[1]), 1'b0, EXP_TRAP);
        step("trap_reset", 1'b1, 1'b1, 1'b1, ev(3'd5, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("after_trap", 1'b0, 1'b0, 1'b0, EXP_IDLE_FETCH);

        // R-type funct3=011 is illegal
        set_instr(32'h00003033);
        step("r011_fetch",  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("r011_decode", 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("r011_trap",   1'b0, 1'b0, 1'b0, EXP_TRAP);
        step("r011_reset",  1'b0, 1'b0, 1'b1, ev(3'd5, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));

        // fetch timeout: 17 FETCH cycles, then TRAP
        for (int i = 0; i < 17; i++)
            step("fto_wait", 1'b0, 1'b0, 1'b0, EXP_IDLE_FETCH);
        step("fto_trap",  1'b0, 1'b0, 1'b0, EXP_TRAP);
        step("fto_reset", 1'b0, 1'b0, 1'b1, ev(3'd5, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));

        // ready on the last allowed cycle wins
        set_instr(32'h00500093);
        for (int i = 0; i < 16; i++)
            step("flast_wait", 1'b0, 1'b0, 1'b0, EXP_IDLE_FETCH);
        step("flast_done",   1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("flast_decode", 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("flast_exec",   1'b0, 1'b0, 1'b0, ev(3'd2, SB_WR, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));

        // reset in the middle of a data wait
        set_instr(32'h00402103);
        step("mr_fetch",  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("mr_decode", 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("mr_exec",   1'b0, 1'b0, 1'b0, ev(3'd2, SB_NONE, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        step("mr_wait0",  1'b0, 1'b0, 1'b0, ev(3'd3, SB_LOAD, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        step("mr_wait1",  1'b0, 1'b0, 1'b0, ev(3'd3, SB_LOAD, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        step("mr_reset",  1'b0, 1'b0, 1'b1, ev(3'd3, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("mr_after",  1'b0, 1'b0, 1'b0, EXP_IDLE_FETCH);

        // data timeout: 17 MEM cycles, then TRAP
        step("dto_fetch",  1'b1, 1'b0, 1'b0, ev(3'd0, SB_FDONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("dto_decode", 1'b0, 1'b0, 1'b0, ev(3'd1, SB_NONE, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0));
        step("dto_exec",   1'b0, 1'b0, 1'b0, ev(3'd2, SB_NONE, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        for (int i = 0; i < 17; i++)
            step("dto_wait", 1'b0, 1'b0, 1'b0, ev(3'd3, SB_LOAD, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0));
        step("dto_trap", 1'b0, 1'b1, 1'b0, EXP_TRAP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
